// File: rtl/sipo_deser_if.sv
// Serial-in / parallel-out bus bundle: serial side from the producer,
// word side toward the downstream 4-bit parallel-load register stage.
`timescale 1ns/1ps
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 4
);
  logic                     in;
  logic                     in_valid;
  logic                     clear;
  logic [WIDTH-1:0]         out;
  logic                     load;
  logic [$clog2(WIDTH):0]   count;
  logic                     partial;

  modport master (
    output in, in_valid, clear,
    input  out, load, count, partial
  );

  modport slave (
    input  in, in_valid, clear,
    output out, load, count, partial
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles WIDTH-bit words from
// qualified serial bits and presents each completed word with a one-cycle load.
`timescale 1ns/1ps
module sipo_deser #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          reset,
  sipo_deser_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {shreg_q[WIDTH-2:0], bus.in};
    else           shifted = {bus.in, shreg_q[WIDTH-1:1]};
  end

  // clear outranks a valid bit, so a flush on the completing edge drops the word
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    load_d  = 1'b0;
    if (bus.clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (bus.in_valid) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        out_d   = shifted;
        load_d  = 1'b1;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      load_q  <= load_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.load    = load_q;
  assign bus.count   = cnt_q;
  assign bus.partial = |cnt_q;
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: MSB-first and LSB-first instances share stimulus;
// expected words are queued at the completing bit and popped when load is seen.
`timescale 1ns/1ps
module tb_sipo_deser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_in = 1'b0;
  logic s_valid = 1'b0;
  logic s_clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(4)) bus_m ();
  sipo_deser_if #(.WIDTH(4)) bus_l ();

  assign bus_m.in       = s_in;
  assign bus_m.in_valid = s_valid;
  assign bus_m.clear    = s_clear;
  assign bus_l.in       = s_in;
  assign bus_l.in_valid = s_valid;
  assign bus_l.clear    = s_clear;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive on the falling edge, return 1 ns after the rising edge
  task automatic step(input logic b, input logic v, input logic c);
    @(negedge clk);
    s_in = b; s_valid = v; s_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] m, input logic [3:0] l);
    q_m.push_back(m);
    q_l.push_back(l);
  endtask

  task automatic release_reset();
    @(negedge clk);
    s_in = 1'b0; s_valid = 1'b0; s_clear = 1'b0;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus_m.load === 1'b1) begin
      if (q_m.size() == 0) chk("load_m_unexpected", {31'd0, bus_m.load}, 32'd0);
      else chk("word_m", {28'd0, bus_m.out}, {28'd0, q_m.pop_front()});
    end
    if (bus_l.load === 1'b1) begin
      if (q_l.size() == 0) chk("load_l_unexpected", {31'd0, bus_l.load}, 32'd0);
      else chk("word_l", {28'd0, bus_l.out}, {28'd0, q_l.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] cnt_exp[7];
    logic       gv[7];
    logic       gb[7];

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out", {28'd0, bus_m.out}, 32'd0);
    chk("rst_count", {29'd0, bus_m.count}, 32'd0);
    chk("rst_load", {31'd0, bus_m.load}, 32'd0);
    chk("rst_partial", {31'd0, bus_m.partial}, 32'd0);
    release_reset();

    // basic word 1,0,1,1
    step(1'b1, 1'b1, 1'b0); chk("w1_cnt1", {29'd0, bus_m.count}, 32'd1);
    chk("w1_part1", {31'd0, bus_m.partial}, 32'd1);
    step(1'b0, 1'b1, 1'b0); chk("w1_cnt2", {29'd0, bus_m.count}, 32'd2);
    step(1'b1, 1'b1, 1'b0); chk("w1_cnt3", {29'd0, bus_l.count}, 32'd3);
    push(4'b1011, 4'b1101);
    step(1'b1, 1'b1, 1'b0); chk("w1_cnt0", {29'd0, bus_m.count}, 32'd0);
    chk("w1_part0", {31'd0, bus_m.partial}, 32'd0);
    chk("w1_load", {31'd0, bus_m.load}, 32'd1);
    step(1'b0, 1'b0, 1'b0); chk("w1_load_off", {31'd0, bus_m.load}, 32'd0);
    chk("w1_out_hold", {28'd0, bus_m.out}, 32'hB);

    // gapped input; gap bits driven as 1 to show they are ignored
    gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cnt_exp = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 7; i++) begin
      if (i == 6) push(4'b0110, 4'b0110);
      step(gb[i], gv[i], 1'b0);
      chk($sformatf("gap_cnt%0d", i), {29'd0, bus_m.count}, {29'd0, cnt_exp[i]});
    end
    step(1'b0, 1'b0, 1'b0);

    // preload A, then clear mid-word
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    push(4'hA, 4'h5);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("clr_pre_cnt", {29'd0, bus_m.count}, 32'd2);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", {29'd0, bus_m.count}, 32'd0);
    chk("clr_partial", {31'd0, bus_m.partial}, 32'd0);
    chk("clr_out_m", {28'd0, bus_m.out}, 32'hA);
    chk("clr_out_l", {28'd0, bus_l.out}, 32'h5);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    push(4'h3, 4'hC);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // clear on the completing edge: no word
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clrc_cnt", {29'd0, bus_m.count}, 32'd0);
    chk("clrc_load", {31'd0, bus_m.load}, 32'd0);
    chk("clrc_out_m", {28'd0, bus_m.out}, 32'h3);
    chk("clrc_out_l", {28'd0, bus_l.out}, 32'hC);

    // streaming two words back to back
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    push(4'h9, 4'h9);
    step(1'b1, 1'b1, 1'b0); chk("st_load0", {31'd0, bus_m.load}, 32'd1);
    step(1'b0, 1'b1, 1'b0); chk("st_gap1", {31'd0, bus_m.load}, 32'd0);
    step(1'b1, 1'b1, 1'b0); chk("st_gap2", {31'd0, bus_m.load}, 32'd0);
    step(1'b1, 1'b1, 1'b0); chk("st_gap3", {31'd0, bus_m.load}, 32'd0);
    push(4'h7, 4'hE);
    step(1'b1, 1'b1, 1'b0); chk("st_load1", {31'd0, bus_m.load}, 32'd1);

    // async reset right after a completing edge kills the pulse (word not queued)
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ar_load_pre", {31'd0, bus_m.load}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_load", {31'd0, bus_m.load}, 32'd0);
    chk("ar_load_l", {31'd0, bus_l.load}, 32'd0);
    chk("ar_out", {28'd0, bus_m.out}, 32'd0);
    release_reset();

    // async reset mid-word
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    chk("arp_pre_cnt", {29'd0, bus_m.count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("arp_cnt", {29'd0, bus_m.count}, 32'd0);
    chk("arp_partial", {31'd0, bus_m.partial}, 32'd0);
    chk("arp_out_l", {28'd0, bus_l.out}, 32'd0);
    release_reset();

    // first edge after reset is bit 0 of a fresh word
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    push(4'b1011, 4'b1101);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);

    chk("q_m_drained", q_m.size(), 32'd0);
    chk("q_l_drained", q_l.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer that sits directly upstream of the 4-bit parallel-load register stage. It accepts one qualified serial bit per clock, assembles `WIDTH`-bit words, and presents each completed word on `out` with a one-cycle `load` pulse. `load` connects to the downstream register's `load` input and `out` to its `in`, so that stage captures each word exactly once.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `out[WIDTH-1]`; 0 means the first received bit lands in `out[0]`.

- `clk`  input  1  single clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset. It clears all state immediately, independent of `clk`.
- `in`  input  1  serial data bit. It is sampled only when `in_valid` is 1.
- `in_valid`  input  1  qualifies `in` on this rising edge.
- `clear`  input  1  synchronous flush. It discards the partial word and does not alter `out`.
- `out`  output  `WIDTH`  last completed word; held between completions.
- `load`  output  1  one-cycle pulse; high in the cycle after a word completes.
- `count`  output  `$clog2(WIDTH)+1`  number of bits of the current partial word already received (0..`WIDTH-1`).
- `partial`  output  1  high when `count != 0`.

## Operation
- **Internal state**
  - `shreg[WIDTH-1:0]`: assembly register.
  - `cnt`: bit counter, driven onto `count`.
  - `out` register.
  - `load` register.
- **Reset (asynchronous, any time, including mid-word)**
  - `shreg`, `cnt`, `out` and `load` go to 0 immediately.
  - `partial` goes to 0.
  - Bits in flight are lost.
  - The first edge after `reset` deasserts is treated as bit 0 of a new word.
- **Per rising edge, evaluated in priority order:**
  1. `clear`=1:
     - `cnt` and `shreg` become 0, and `load` becomes 0.
     - `out` holds.
     - `in_valid` is ignored this edge; the bit is dropped.
  2. `in_valid`=1 and `cnt < WIDTH-1`:
     - The bit is shifted in and `cnt` increments; `load` becomes 0.
     - With `MSB_FIRST`=1: `shreg <= {shreg[WIDTH-2:0], in}`.
     - With `MSB_FIRST`=0: `shreg <= {in, shreg[WIDTH-1:1]}`.
  3. `in_valid`=1 and `cnt == WIDTH-1` (word completes):
     - `out` takes the shifted value, including the current bit.
     - `load` becomes 1.
     - `cnt` wraps to 0, and `shreg` becomes 0.
  4. Otherwise:
     - `shreg`, `cnt` and `out` hold.
     - `load` becomes 0.
- **Word contents:** `out` never shows a partial word; it changes only on completion.
- **Overruns:** none can occur. The downstream stage has no back-pressure, so every completion overwrites `out`.
- **`load` length:** `load` is never high for two consecutive cycles when `WIDTH` ≥ 2.
- **Gaps:** gaps in `in_valid` of any length are allowed inside a word. The counter simply waits.
- **Combinational path:** `partial` is the only combinational output, decoded from `cnt`. All other outputs are direct register outputs.

## Timing
- **Per-bit latency:** a bit is captured on the rising edge where `in_valid`=1.
- **Word latency:**
  - The final bit is sampled on edge N.
  - `out` and `load`=1 are valid from just after edge N until edge N+1.
  - The downstream register loads on edge N+1.
- **Throughput:** with continuous `in_valid`, `load` pulses once every `WIDTH` cycles. The first pulse follows edge `WIDTH`-1 counted from 0.
- **`clear` on the completing edge:** `clear` wins. There is no `load` pulse, and `out` keeps its previous word.
- **`reset` between edges N and N+1:** `load` drops immediately, so the downstream stage does not see the pulse at edge N+1.
- **`count` and `partial`:** update on the same edge as the captured bit.

## Test plan
- **MSB-first word** (`WIDTH`=4, `MSB_FIRST`=1): after reset, drive `in`=1,0,1,1 with `in_valid`=1 on four consecutive edges.
  - `count` steps 1,2,3,0.
  - `out`=4'b1011, and `load`=1 for exactly one cycle after the 4th edge.
- **LSB-first word:** same stimulus with `MSB_FIRST`=0.
  - `out`=4'b1101 and a single `load` pulse.
- **Gapped input:** `in_valid` pattern 1,0,0,1,0,1,1 with bits 0,x,x,1,x,1,0 (MSB first).
  - `out`=4'b0110 after the last valid edge.
  - `count` holds its value during the gaps.
  - Exactly one `load` pulse.
- **Clear mid-word:** preload `out`=4'hA, then shift 1,1, then assert `clear`.
  - `count`=0 and `partial`=0; `out` stays 4'hA.
  - A following 0,0,1,1 yields `out`=4'h3.
- **Clear on completing edge:** shift three bits, then apply the fourth with `clear`=1 on the same edge.
  - No `load` pulse; `out` unchanged; `count`=0.
- **Streaming and async reset:** 8 consecutive valid bits 1,0,0,1,0,1,1,1.
  - `load` pulses twice, 4 cycles apart, with `out`=4'h9 then 4'h7.
  - Asserting `reset` mid-cycle during a later partial word forces `out`=0, `count`=0 and `load`=0 immediately, without waiting for a clock edge.
